// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, memory-stage FSM states and SC writeback codes.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} memstate_t;

  localparam word_t SC_PASS = 32'd1;
  localparam word_t SC_FAIL = 32'd0;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: holds the linked word address and its valid bit, and reports
// address/snoop matches at word granularity.
module llsc_link_reg #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned LINK_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ll_hit,
  input  logic              store_hit,
  input  logic [WORD_W-1:0] addr,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              link_valid,
  output logic              addr_match,
  output logic              snoop_match
);

  logic [WORD_W-1:LINK_LSB] link_addr;
  logic                     snoop_hits_new;

  assign addr_match     = (link_addr == addr[WORD_W-1:LINK_LSB]);
  assign snoop_match    = (link_addr == snoop_addr[WORD_W-1:LINK_LSB]);
  // An invalidate racing an LL to the same word leaves the new link dead.
  assign snoop_hits_new = snoop_inv & (snoop_addr[WORD_W-1:LINK_LSB] == addr[WORD_W-1:LINK_LSB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_hit) begin
      link_addr  <= addr[WORD_W-1:LINK_LSB];
      link_valid <= ~snoop_hits_new;
    end else if ((store_hit & addr_match) | (snoop_inv & snoop_match)) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: dcache handshake, load capture, MEM/WB enable, sticky halt.
// Define MEM_LLSC_EN to enable LL/SC link tracking and a real sc_result.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned LINK_LSB = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              datomic_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              halt_in,
  input  logic              pipe_stall,
  input  logic              flush_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemload_out,
  output logic [WORD_W-1:0] sc_result,
  output logic              mem_busy,
  output logic              memwb_enable,
  output logic              halt_out
);

  memstate_t         state;
  logic              halted;
  logic [WORD_W-1:0] load_q;
  logic              req;
  logic              active;
  logic              done;
  logic              sc_fail;

  assign req    = (dREN_in | dWEN_in) & ~halted & ~sc_fail;
  // RST gates the strobes so they drop the instant reset is asserted.
  assign active = ~RST & (state != HOLD) & req;
  assign done   = active & dhit;

  assign dmemREN      = active & dREN_in;
  assign dmemWEN      = active & dWEN_in;
  assign dmemaddr     = addr_in;
  assign dmemstore    = store_in;
  assign dmemload_out = dhit ? dmemload : load_q;
  assign mem_busy     = ~RST & ~dhit & ((state == ACCESS) | ((state == IDLE) & req));
  assign memwb_enable = ~mem_busy & ~pipe_stall;
  assign halt_out     = halted;

`ifdef MEM_LLSC_EN
  logic link_valid;
  logic addr_match;
  logic snoop_match;
  logic sc_op;
  logic sc_now;
  logic sc_q;

  assign sc_op   = datomic_in & dWEN_in;
  // The SC decision is made at issue; an SC already in ACCESS always completes.
  assign sc_fail = sc_op & (state == IDLE) &
                   ~(link_valid & addr_match & ~(snoop_inv & snoop_match));
  assign sc_now  = sc_op & ~sc_fail;

  always_comb begin
    sc_result = WORD_W'(SC_FAIL);
    if (~RST & ((state == HOLD) ? sc_q : sc_now)) sc_result = WORD_W'(SC_PASS);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sc_q <= 1'b0;
    else if (done) sc_q <= sc_now;
  end

  llsc_link_reg #(
    .WORD_W   (WORD_W),
    .LINK_LSB (LINK_LSB)
  ) u_link (
    .clk         (CLK),
    .rst         (RST),
    .ll_hit      (done & dREN_in & datomic_in),
    .store_hit   (done & dWEN_in),
    .addr        (addr_in),
    .snoop_inv   (snoop_inv),
    .snoop_addr  (snoop_addr),
    .link_valid  (link_valid),
    .addr_match  (addr_match),
    .snoop_match (snoop_match)
  );
`else
  logic unused_llsc;

  assign sc_fail     = 1'b0;
  assign sc_result   = WORD_W'(SC_PASS);
  assign unused_llsc = ^{datomic_in, snoop_inv, snoop_addr};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      halted <= 1'b0;
      load_q <= '0;
    end else begin
      if (halt_in & memwb_enable) halted <= 1'b1;
      if (dmemREN & dhit) load_q <= dmemload;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (!dhit) state <= ACCESS;
            else if (pipe_stall) state <= HOLD;
          end
        end
        ACCESS: begin
          if (dhit) state <= pipe_stall ? HOLD : IDLE;
        end
        HOLD: begin
          // Parked until the stall clears, so the access is never re-issued.
          if (!pipe_stall || flush_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; LL/SC scenarios follow MEM_LLSC_EN.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dREN_in, dWEN_in, datomic_in, halt_in, pipe_stall, flush_in, dhit, snoop_inv;
  logic [31:0] addr_in, store_in, dmemload, snoop_addr;
  logic        dmemREN, dmemWEN, mem_busy, memwb_enable, halt_out;
  logic [31:0] dmemaddr, dmemstore, dmemload_out, sc_result;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.WORD_W(32), .LINK_LSB(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .dREN_in      (dREN_in),
    .dWEN_in      (dWEN_in),
    .datomic_in   (datomic_in),
    .addr_in      (addr_in),
    .store_in     (store_in),
    .halt_in      (halt_in),
    .pipe_stall   (pipe_stall),
    .flush_in     (flush_in),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .dmemaddr     (dmemaddr),
    .dmemstore    (dmemstore),
    .dmemload_out (dmemload_out),
    .sc_result    (sc_result),
    .mem_busy     (mem_busy),
    .memwb_enable (memwb_enable),
    .halt_out     (halt_out)
  );

  task automatic clear_inputs();
    dREN_in = 0; dWEN_in = 0; datomic_in = 0; halt_in = 0; pipe_stall = 0; flush_in = 0;
    dhit = 0; snoop_inv = 0; addr_in = 0; store_in = 0; dmemload = 0; snoop_addr = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] flags;
    RST = 1'b1;
    clear_inputs();
    step();
    step();
    #1;
    flags = {dmemREN, dmemWEN, mem_busy, memwb_enable};
    checks++;
    if (flags !== 4'b0001) begin
      errors++; $display("FAIL reset_flags got %b want 0001", flags);
    end
    checks++;
    if ({halt_out, dmemload_out} !== 33'd0) begin
      errors++; $display("FAIL reset_state halt=%b load=%h want 0/0", halt_out, dmemload_out);
    end
    checks++;
`ifdef MEM_LLSC_EN
    if (sc_result !== 32'd0) begin
      errors++; $display("FAIL reset_sc got %h want 0", sc_result);
    end
`else
    if (sc_result !== 32'd1) begin
      errors++; $display("FAIL reset_sc got %h want 1", sc_result);
    end
`endif
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_lw_miss();
    logic [3:0] flags;
    logic [3:0] want;
    dREN_in = 1; addr_in = 32'h40;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dhit = 1; dmemload = 32'hDEADBEEF; end
      #1;
      flags = {dmemREN, dmemWEN, mem_busy, memwb_enable};
      want  = (i == 3) ? 4'b1001 : 4'b1010;
      checks++;
      if (flags !== want) begin
        errors++; $display("FAIL lw_miss_c%0d got %b want %b", i, flags, want);
      end
      checks++;
      if (dmemaddr !== 32'h40) begin
        errors++; $display("FAIL lw_miss_addr got %h want 00000040", dmemaddr);
      end
      if (i == 3) begin
        checks++;
        if (dmemload_out !== 32'hDEADBEEF) begin
          errors++; $display("FAIL lw_miss_data got %h want deadbeef", dmemload_out);
        end
      end
      step();
    end
    clear_inputs();
    #1;
    checks++;
    if ({mem_busy, dmemload_out} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw_miss_after busy=%b load=%h want 0/deadbeef", mem_busy,
                         dmemload_out);
    end
    step();
  endtask

  task automatic test_lw_stall();
    logic [3:0] flags;
    logic [3:0] want;
    int         ren_cycles = 0;
    dREN_in = 1; addr_in = 32'h44; dhit = 1; dmemload = 32'h12345678; pipe_stall = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pipe_stall = 0;
      #1;
      if (dmemREN) ren_cycles++;
      flags = {dmemREN, dmemWEN, mem_busy, memwb_enable};
      want  = (i == 0) ? 4'b1000 : (i == 3) ? 4'b0001 : 4'b0000;
      checks++;
      if (flags !== want) begin
        errors++; $display("FAIL lw_stall_c%0d got %b want %b", i, flags, want);
      end
      checks++;
      if (dmemload_out !== 32'h12345678) begin
        errors++; $display("FAIL lw_stall_data_c%0d got %h want 12345678", i, dmemload_out);
      end
      step();
      dhit = 0; dmemload = 32'h0BAD0BAD;
    end
    checks++;
    if (ren_cycles !== 1) begin
      errors++; $display("FAIL lw_stall_ren got %0d want 1", ren_cycles);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_flush_hold();
    dREN_in = 1; addr_in = 32'h48; dhit = 1; dmemload = 32'h1; pipe_stall = 1;
    step();
    dhit = 0; flush_in = 1;
    #1;
    checks++;
    if (dmemREN !== 1'b0) begin
      errors++; $display("FAIL flush_hold_ren got %b want 0", dmemREN);
    end
    step();
    flush_in = 0;
    #1;
    checks++;
    if ({dmemREN, mem_busy} !== 2'b11) begin
      errors++; $display("FAIL flush_reissue got %b want 11", {dmemREN, mem_busy});
    end
    dhit = 1; pipe_stall = 0;
    step();
    clear_inputs();
    step();
  endtask

  // One directed LL/SC transaction: drive, check strobes and sc_result, advance.
  task automatic llsc_op(input string name, input logic is_ll, input logic [31:0] a,
                         input logic hit, input logic sinv, input logic [31:0] saddr,
                         input logic want_wen, input logic [31:0] want_sc);
    clear_inputs();
    datomic_in = 1; dREN_in = is_ll; dWEN_in = ~is_ll; addr_in = a; store_in = 32'h5;
    dhit = hit; snoop_inv = sinv; snoop_addr = saddr;
    #1;
    if (!is_ll) begin
      checks++;
      if ({dmemWEN, sc_result} !== {want_wen, want_sc}) begin
        errors++; $display("FAIL %s wen=%b sc=%h want %b/%h", name, dmemWEN, sc_result,
                           want_wen, want_sc);
      end
    end
    step();
    clear_inputs();
  endtask

`ifdef MEM_LLSC_EN
  task automatic test_llsc();
    llsc_op("ll_a", 1, 32'h80, 1, 0, 0, 0, 0);
    llsc_op("sc_pass", 0, 32'h80, 1, 0, 0, 1, 32'd1);
    llsc_op("sc_again", 0, 32'h80, 0, 0, 0, 0, 32'd0);
    checks++;
    if (mem_busy !== 1'b0) begin
      errors++; $display("FAIL sc_fail_busy got %b want 0", mem_busy);
    end
    llsc_op("ll_b", 1, 32'h80, 1, 0, 0, 0, 0);
    llsc_op("sc_word_snoop_other", 0, 32'h82, 1, 1, 32'h84, 1, 32'd1);
    llsc_op("ll_c", 1, 32'h80, 1, 0, 0, 0, 0);
    llsc_op("snoop_84", 0, 32'h0, 0, 0, 0, 0, 32'd0);
    clear_inputs(); snoop_inv = 1; snoop_addr = 32'h80;
    step();
    llsc_op("sc_after_snoop", 0, 32'h80, 1, 0, 0, 0, 32'd0);
    llsc_op("ll_snoop_same", 1, 32'h80, 1, 1, 32'h80, 0, 0);
    llsc_op("sc_after_ll_snoop", 0, 32'h80, 1, 0, 0, 0, 32'd0);
    llsc_op("ll_d", 1, 32'h80, 1, 0, 0, 0, 0);
    llsc_op("sc_with_snoop", 0, 32'h80, 1, 1, 32'h80, 0, 32'd0);
  endtask
`else
  task automatic test_llsc();
    llsc_op("ll_as_lw", 1, 32'h80, 1, 0, 0, 0, 0);
    llsc_op("sc_as_sw", 0, 32'h80, 1, 1, 32'h80, 1, 32'd1);
    llsc_op("sc_as_sw2", 0, 32'h80, 1, 0, 0, 1, 32'd1);
  endtask
`endif

  task automatic test_rst_access();
    llsc_op("ll_pre_rst", 1, 32'h80, 1, 0, 0, 0, 0);
    dREN_in = 1; addr_in = 32'h100;
    step();
    #1;
    checks++;
    if ({dmemREN, mem_busy} !== 2'b11) begin
      errors++; $display("FAIL rst_access_pre got %b want 11", {dmemREN, mem_busy});
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_busy} !== 3'b000) begin
      errors++; $display("FAIL rst_async got %b want 000", {dmemREN, dmemWEN, mem_busy});
    end
    step();
    clear_inputs();
    RST = 1'b0;
    step();
`ifdef MEM_LLSC_EN
    llsc_op("sc_after_rst", 0, 32'h80, 1, 0, 0, 0, 32'd0);
`else
    llsc_op("sc_after_rst", 0, 32'h80, 1, 0, 0, 1, 32'd1);
`endif
  endtask

  task automatic test_halt();
    clear_inputs();
    halt_in = 1;
    #1;
    checks++;
    if (memwb_enable !== 1'b1) begin
      errors++; $display("FAIL halt_enable got %b want 1", memwb_enable);
    end
    step();
    halt_in = 0; dREN_in = 1; addr_in = 32'h40; dhit = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({halt_out, dmemREN, mem_busy} !== 3'b100) begin
        errors++; $display("FAIL halt_c%0d got %b want 100", i, {halt_out, dmemREN, mem_busy});
      end
      step();
    end
    RST = 1'b1;
    #1;
    step();
    RST = 1'b0;
    #1;
    checks++;
    if ({halt_out, dmemREN} !== 2'b01) begin
      errors++; $display("FAIL halt_cleared got %b want 01", {halt_out, dmemREN});
    end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_miss();
    test_lw_stall();
    test_flush_hold();
    test_llsc();
    test_rst_access();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
